abm_unloader: RTL and testbench
===============================

// Module: abm_unloader
// PURPOSE
// - Copies a fixed-size block from ABM RAM (AXI4 read master) to a host RAM buffer over PCIe (AXI4 write master).
// - Inverse direction of the ABM load path; lets the host read back ABM contents.
// - Independent read and write FSMs decoupled by an internal FIFO; up to 2 bursts are read ahead of the writes.
// PARAMETERS
// DW          512       AXI data width, both ports
// AW          64        AXI address width, both ports
// ABM_ADDR    0         ABM source base address
// BYTE_COUNT  'h10_0000 bytes per transfer; multiple of BURST_BYTES
// BURST_BYTES 4096      bytes per burst; <=4096, multiple of DW/8, BURST_BYTES/(DW/8)<=256
// PORTS
// clk             in   1     clock
// reset           in   1     synchronous, active-high reset
// pci_dst_addr    in   64    host destination byte address
// unload          in   1     start request value
// unload_wstrobe  in   1     qualifies unload
// idle            out  1     1 = no transfer in progress
// slave_select    out  1     equals !idle
// error           out  1     sticky: a non-OKAY RRESP or BRESP was seen
// ABM_AXI_AR*     out  -     ADDR[AW],VALID,LEN[8],SIZE[3],ID[4],BURST[2],LOCK,CACHE[4],QOS[4],PROT[3]; ARREADY in
// ABM_AXI_R*      in   -     DATA[DW],VALID,RESP[2],LAST; RREADY out
// PCI_AXI_AW*     out  -     same field set as AR; AWREADY in
// PCI_AXI_W*      out  -     DATA[DW],STRB[DW/8],VALID,LAST; WREADY in
// PCI_AXI_B*      in   -     RESP[2],VALID; BREADY out
// BEHAVIOUR
// - Reset values: idle=1, slave_select=0, error=0; all VALID/READY outputs 0. FIFO flushed, FSMs return to IDLE.
//   Reset mid-transfer aborts it with no drain.
// - Derived values: BEATS=BURST_BYTES/(DW/8), NBURST=BYTE_COUNT/BURST_BYTES.
//   ARLEN=AWLEN=BEATS-1; SIZE=log2(DW/8); BURST=INCR; ID/LOCK/QOS/PROT=0; CACHE=4'b0011; WSTRB all ones.
// - Start accepted only when all hold: !reset, idle, unload_wstrobe, unload, pci_dst_addr!=0,
//   pci_dst_addr[log2(BURST_BYTES)-1:0]==0. Otherwise the request is ignored; a request while busy is ignored.
// - Accepted start latches pci_dst_addr and clears error. idle falls on the next clock, and ARVALID may
//   rise on that same clock.
// - Read FSM (R_IDLE->R_AR->R_DATA->R_AR|R_IDLE):
//   - ARADDR = ABM_ADDR + k*BURST_BYTES.
//   - R_AR is entered only when FIFO free space minus reserved space >= BEATS; BEATS are reserved at AR issue.
//   - RREADY=1 throughout R_DATA. The beat counter is authoritative; RLAST is ignored.
//   - Return to R_IDLE after NBURST bursts.
// - Write FSM (W_IDLE->W_AW->W_DATA->W_B->W_AW|W_IDLE):
//   - W_AW is entered when FIFO holds >= BEATS. AWADDR = latched dst + k*BURST_BYTES (64-bit, modulo 2^64).
//   - WVALID = W_DATA & FIFO non-empty. WLAST on beat BEATS-1.
//   - BREADY=1 only in W_B.
// - AR/AW VALID hold their address stable until the READY handshake completes; no combinational READY->VALID paths.
// - Non-OKAY RRESP on any beat, or non-OKAY BRESP, sets error. The transfer still runs to completion; no retry.
// - idle rises the clock after the NBURST-th B handshake.
// - FIFO depth is 2*BEATS; it can never overflow (reservation) or underflow (WVALID gated).
// - Simultaneous FIFO push and pop on the same clock is supported.
// STRUCTURE
// - Shared package abm_axi_pkg: AXI_BURST_INCR, AXI_CACHE_DEFAULT, AXI_RESP_OKAY, and clog2-derived size/beat helpers.
// - One sub-module, abm_sync_fifo (DW wide, depth 2*BEATS, sync reset, full/empty/count outputs).
//   The FSMs, counters and address math live in abm_unloader.
// TESTING
// 1. Reset asserted 3 clocks -> idle=1, slave_select=0, error=0, every VALID/READY output 0.
// 2. Defaults, pci_dst_addr=0x1_0000_0000, unload strobe:
//    -> 256 ARs (0x0..0xFF000) and 256 AWs (0x1_0000_0000+k*0x1000), LEN=63.
//    -> 16384 W beats match source data; idle=1 after the last B.
// 3. pci_dst_addr=0, then 0x1000_0800, then unload=0 with wstrobe -> no AR issued; idle stays 1.
// 4. AWREADY/WREADY randomly low 70%, ARREADY 5-cycle delay:
//    -> data intact, at most 2 bursts read ahead, FIFO never overflows, WLAST only on beat 63.
// 5. BRESP=SLVERR on burst 5 and RRESP=SLVERR on one beat of burst 9:
//    -> error=1, all 256 bursts still complete; next accepted start clears error.
// 6. Reset pulse after 100 W beats, then a fresh start:
//    -> all VALIDs 0 the next clock, idle=1; the second transfer completes byte-exact.

Source files
------------

// File: rtl/abm_axi_pkg.sv
// Shared AXI encodings and burst-geometry helpers for the ABM transfer engines.
package abm_axi_pkg;

  localparam logic [1:0] AXI_BURST_INCR    = 2'b01;
  localparam logic [3:0] AXI_CACHE_DEFAULT = 4'b0011;
  localparam logic [1:0] AXI_RESP_OKAY     = 2'b00;

  function automatic int axi_size_for(input int dw);
    return $clog2(dw / 8);
  endfunction

  function automatic int beats_per_burst(input int burst_bytes, input int dw);
    return burst_bytes / (dw / 8);
  endfunction

endpackage

// File: rtl/abm_sync_fifo.sv
// Single-clock FIFO with first-word-fall-through read and occupancy count.
module abm_sync_fifo #(
  parameter  int DW    = 512,
  parameter  int DEPTH = 128,
  localparam int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          push,
  input  logic [DW-1:0] push_data,
  input  logic          pop,
  output logic [DW-1:0] pop_data,
  output logic          full,
  output logic          empty,
  output logic [CW-1:0] count
);

  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [DW-1:0] mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  function automatic logic [PW-1:0] next_ptr(input logic [PW-1:0] p);
    return (p == PW'(DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  assign do_push  = push && !full;
  assign do_pop   = pop && !empty;
  assign full     = (count == CW'(DEPTH));
  assign empty    = (count == '0);
  assign pop_data = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= next_ptr(wr_ptr);
      if (do_pop)  rd_ptr <= next_ptr(rd_ptr);
      case ({do_push, do_pop})
        2'b10:   count <= count + 1'b1;
        2'b01:   count <= count - 1'b1;
        default: count <= count;
      endcase
    end
  end

  // Storage carries no reset; the pointers define which entries are valid.
  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

endmodule

// File: rtl/abm_unloader.sv
// Streams a fixed-size block from ABM RAM to a host buffer: an AXI read engine
// fills a FIFO ahead of an independent AXI write engine that drains it.
module abm_unloader
  import abm_axi_pkg::*;
#(
  parameter int             DW          = 512,
  parameter int             AW          = 64,
  parameter logic [AW-1:0]  ABM_ADDR    = '0,
  parameter int             BYTE_COUNT  = 'h10_0000,
  parameter int             BURST_BYTES = 4096
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [63:0]     pci_dst_addr,
  input  logic            unload,
  input  logic            unload_wstrobe,
  output logic            idle,
  output logic            slave_select,
  output logic            error,
  output logic [AW-1:0]   ABM_AXI_ARADDR,
  output logic            ABM_AXI_ARVALID,
  output logic [7:0]      ABM_AXI_ARLEN,
  output logic [2:0]      ABM_AXI_ARSIZE,
  output logic [3:0]      ABM_AXI_ARID,
  output logic [1:0]      ABM_AXI_ARBURST,
  output logic            ABM_AXI_ARLOCK,
  output logic [3:0]      ABM_AXI_ARCACHE,
  output logic [3:0]      ABM_AXI_ARQOS,
  output logic [2:0]      ABM_AXI_ARPROT,
  input  logic            ABM_AXI_ARREADY,
  input  logic [DW-1:0]   ABM_AXI_RDATA,
  input  logic            ABM_AXI_RVALID,
  input  logic [1:0]      ABM_AXI_RRESP,
  input  logic            ABM_AXI_RLAST,
  output logic            ABM_AXI_RREADY,
  output logic [AW-1:0]   PCI_AXI_AWADDR,
  output logic            PCI_AXI_AWVALID,
  output logic [7:0]      PCI_AXI_AWLEN,
  output logic [2:0]      PCI_AXI_AWSIZE,
  output logic [3:0]      PCI_AXI_AWID,
  output logic [1:0]      PCI_AXI_AWBURST,
  output logic            PCI_AXI_AWLOCK,
  output logic [3:0]      PCI_AXI_AWCACHE,
  output logic [3:0]      PCI_AXI_AWQOS,
  output logic [2:0]      PCI_AXI_AWPROT,
  input  logic            PCI_AXI_AWREADY,
  output logic [DW-1:0]   PCI_AXI_WDATA,
  output logic [DW/8-1:0] PCI_AXI_WSTRB,
  output logic            PCI_AXI_WVALID,
  output logic            PCI_AXI_WLAST,
  input  logic            PCI_AXI_WREADY,
  input  logic [1:0]      PCI_AXI_BRESP,
  input  logic            PCI_AXI_BVALID,
  output logic            PCI_AXI_BREADY
);

  localparam int BEATS  = beats_per_burst(BURST_BYTES, DW);
  localparam int NBURST = BYTE_COUNT / BURST_BYTES;
  localparam int DEPTH  = 2 * BEATS;
  localparam int CW     = $clog2(DEPTH + 1);
  localparam int BTW    = $clog2(BEATS + 1);
  localparam int BCW    = $clog2(NBURST + 1);
  localparam int OFS    = $clog2(BURST_BYTES);

  localparam logic [BTW-1:0] LAST_BEAT  = BTW'(BEATS - 1);
  localparam logic [BCW-1:0] LAST_BURST = BCW'(NBURST - 1);
  localparam logic [AW-1:0]  BURST_STEP = AW'(BURST_BYTES);

  typedef enum logic [1:0] {R_IDLE, R_AR, R_DATA, R_WAIT} r_state_t;
  typedef enum logic [1:0] {W_IDLE, W_AW, W_DATA, W_B}    w_state_t;

  r_state_t       r_state, r_next;
  w_state_t       w_state, w_next;
  logic           busy;
  logic           start;
  logic [AW-1:0]  ar_addr;
  logic [AW-1:0]  aw_addr;
  logic [BTW-1:0] r_beat;
  logic [BTW-1:0] w_beat;
  logic [BCW-1:0] r_burst;
  logic [BCW-1:0] w_burst;
  logic [CW-1:0]  reserved;
  logic [CW:0]    committed;
  logic           space_ok;
  logic           ar_hs, aw_hs, b_hs;
  logic           push, pop;
  logic           fifo_full, fifo_empty;
  logic [CW-1:0]  fifo_count;
  logic           unused_sigs;

  assign start = !reset && !busy && unload_wstrobe && unload &&
                 (pci_dst_addr != '0) && (pci_dst_addr[OFS-1:0] == '0);

  assign ar_hs = ABM_AXI_ARVALID && ABM_AXI_ARREADY;
  assign aw_hs = PCI_AXI_AWVALID && PCI_AXI_AWREADY;
  assign b_hs  = PCI_AXI_BREADY && PCI_AXI_BVALID;
  assign push  = ABM_AXI_RREADY && ABM_AXI_RVALID;
  assign pop   = (w_state == W_DATA) && !fifo_empty && PCI_AXI_WREADY;

  // Beats already requested but not yet landed count against free space.
  assign committed = {1'b0, fifo_count} + {1'b0, reserved};
  assign space_ok  = (committed <= (CW+1)'(DEPTH - BEATS));

  assign idle         = !busy;
  assign slave_select = busy;

  assign ABM_AXI_ARADDR  = ar_addr;
  assign ABM_AXI_ARLEN   = 8'(BEATS - 1);
  assign ABM_AXI_ARSIZE  = 3'(axi_size_for(DW));
  assign ABM_AXI_ARID    = '0;
  assign ABM_AXI_ARBURST = AXI_BURST_INCR;
  assign ABM_AXI_ARLOCK  = 1'b0;
  assign ABM_AXI_ARCACHE = AXI_CACHE_DEFAULT;
  assign ABM_AXI_ARQOS   = '0;
  assign ABM_AXI_ARPROT  = '0;

  assign PCI_AXI_AWADDR  = aw_addr;
  assign PCI_AXI_AWLEN   = 8'(BEATS - 1);
  assign PCI_AXI_AWSIZE  = 3'(axi_size_for(DW));
  assign PCI_AXI_AWID    = '0;
  assign PCI_AXI_AWBURST = AXI_BURST_INCR;
  assign PCI_AXI_AWLOCK  = 1'b0;
  assign PCI_AXI_AWCACHE = AXI_CACHE_DEFAULT;
  assign PCI_AXI_AWQOS   = '0;
  assign PCI_AXI_AWPROT  = '0;
  assign PCI_AXI_WSTRB   = '1;

  // The beat counter bounds each burst, so RLAST carries no information here.
  assign unused_sigs = ABM_AXI_RLAST ^ fifo_full;

  abm_sync_fifo #(
    .DW    (DW),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk       (clk),
    .reset     (reset),
    .push      (push),
    .push_data (ABM_AXI_RDATA),
    .pop       (pop),
    .pop_data  (PCI_AXI_WDATA),
    .full      (fifo_full),
    .empty     (fifo_empty),
    .count     (fifo_count)
  );

  always_comb begin
    r_next          = r_state;
    ABM_AXI_ARVALID = 1'b0;
    ABM_AXI_RREADY  = 1'b0;
    case (r_state)
      R_IDLE: if (start) r_next = R_AR;
      R_AR: begin
        ABM_AXI_ARVALID = 1'b1;
        if (ABM_AXI_ARREADY) r_next = R_DATA;
      end
      R_DATA: begin
        ABM_AXI_RREADY = 1'b1;
        if (ABM_AXI_RVALID && (r_beat == LAST_BEAT)) begin
          if (r_burst == LAST_BURST) r_next = R_IDLE;
          else if (space_ok)         r_next = R_AR;
          else                       r_next = R_WAIT;
        end
      end
      R_WAIT: if (space_ok) r_next = R_AR;
      default: r_next = R_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state  <= R_IDLE;
      ar_addr  <= ABM_ADDR;
      r_beat   <= '0;
      r_burst  <= '0;
      reserved <= '0;
    end else begin
      r_state <= r_next;
      if (start) begin
        ar_addr <= ABM_ADDR;
        r_burst <= '0;
      end
      if (ar_hs) begin
        ar_addr <= ar_addr + BURST_STEP;
        r_beat  <= '0;
      end
      if (push) begin
        r_beat <= r_beat + 1'b1;
        if (r_beat == LAST_BEAT) r_burst <= r_burst + 1'b1;
      end
      reserved <= reserved + (ar_hs ? CW'(BEATS) : '0) - (push ? CW'(1) : '0);
    end
  end

  always_comb begin
    w_next          = w_state;
    PCI_AXI_AWVALID = 1'b0;
    PCI_AXI_WVALID  = 1'b0;
    PCI_AXI_WLAST   = 1'b0;
    PCI_AXI_BREADY  = 1'b0;
    case (w_state)
      W_IDLE: if (busy && (fifo_count >= CW'(BEATS))) w_next = W_AW;
      W_AW: begin
        PCI_AXI_AWVALID = 1'b1;
        if (PCI_AXI_AWREADY) w_next = W_DATA;
      end
      W_DATA: begin
        PCI_AXI_WVALID = !fifo_empty;
        PCI_AXI_WLAST  = (w_beat == LAST_BEAT);
        if (pop && (w_beat == LAST_BEAT)) w_next = W_B;
      end
      W_B: begin
        PCI_AXI_BREADY = 1'b1;
        if (PCI_AXI_BVALID) begin
          if (w_burst == LAST_BURST)             w_next = W_IDLE;
          else if (fifo_count >= CW'(BEATS))     w_next = W_AW;
          else                                   w_next = W_IDLE;
        end
      end
      default: w_next = W_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      w_state <= W_IDLE;
      aw_addr <= '0;
      w_beat  <= '0;
      w_burst <= '0;
    end else begin
      w_state <= w_next;
      if (start) begin
        aw_addr <= AW'(pci_dst_addr);
        w_burst <= '0;
      end
      if (aw_hs) begin
        aw_addr <= aw_addr + BURST_STEP;
        w_beat  <= '0;
      end
      if (pop)  w_beat  <= w_beat + 1'b1;
      if (b_hs) w_burst <= w_burst + 1'b1;
    end
  end

  // A bad response is recorded but never stops the transfer.
  always_ff @(posedge clk) begin
    if (reset) begin
      busy  <= 1'b0;
      error <= 1'b0;
    end else if (start) begin
      busy  <= 1'b1;
      error <= 1'b0;
    end else begin
      if (push && (ABM_AXI_RRESP != AXI_RESP_OKAY)) error <= 1'b1;
      if (b_hs && (PCI_AXI_BRESP != AXI_RESP_OKAY)) error <= 1'b1;
      if (b_hs && (w_burst == LAST_BURST))          busy  <= 1'b0;
    end
  end

endmodule

// File: tb/tb_abm_unloader.sv
// Directed bench for abm_unloader: AXI slave responders plus a data scoreboard,
// driven from a single stimulus sequence that advances one clock at a time.
module tb_abm_unloader;

  localparam int          DW          = 64;
  localparam int          AW          = 64;
  localparam int          BURST_BYTES = 64;
  localparam int          BYTE_COUNT  = 1024;
  localparam int          BEATS       = 8;
  localparam int          NBURST      = 16;
  localparam logic [63:0] ABM_BASE    = 64'h4000;
  localparam logic [28:0] ATTR_EXP    = {8'd7, 3'd3, 2'b01, 4'b0011, 4'd0, 1'b0, 4'd0, 3'd0};

  logic            clk = 1'b0;
  logic            reset;
  logic [63:0]     pci_dst_addr;
  logic            unload, unload_wstrobe;
  logic            idle, slave_select, error;
  logic [AW-1:0]   ar_addr;
  logic            ar_valid, ar_ready, ar_lock;
  logic [7:0]      ar_len;
  logic [2:0]      ar_size, ar_prot;
  logic [3:0]      ar_id, ar_cache, ar_qos;
  logic [1:0]      ar_burst;
  logic [DW-1:0]   r_data;
  logic            r_valid, r_last, r_ready;
  logic [1:0]      r_resp;
  logic [AW-1:0]   aw_addr;
  logic            aw_valid, aw_ready, aw_lock;
  logic [7:0]      aw_len;
  logic [2:0]      aw_size, aw_prot;
  logic [3:0]      aw_id, aw_cache, aw_qos;
  logic [1:0]      aw_burst;
  logic [DW-1:0]   w_data;
  logic [DW/8-1:0] w_strb;
  logic            w_valid, w_last, w_ready;
  logic [1:0]      b_resp;
  logic            b_valid, b_ready;

  always #5 clk = ~clk;

  abm_unloader #(
    .DW(DW), .AW(AW), .ABM_ADDR(ABM_BASE), .BYTE_COUNT(BYTE_COUNT), .BURST_BYTES(BURST_BYTES)
  ) dut (
    .clk(clk), .reset(reset), .pci_dst_addr(pci_dst_addr), .unload(unload),
    .unload_wstrobe(unload_wstrobe), .idle(idle), .slave_select(slave_select), .error(error),
    .ABM_AXI_ARADDR(ar_addr), .ABM_AXI_ARVALID(ar_valid), .ABM_AXI_ARLEN(ar_len),
    .ABM_AXI_ARSIZE(ar_size), .ABM_AXI_ARID(ar_id), .ABM_AXI_ARBURST(ar_burst),
    .ABM_AXI_ARLOCK(ar_lock), .ABM_AXI_ARCACHE(ar_cache), .ABM_AXI_ARQOS(ar_qos),
    .ABM_AXI_ARPROT(ar_prot), .ABM_AXI_ARREADY(ar_ready),
    .ABM_AXI_RDATA(r_data), .ABM_AXI_RVALID(r_valid), .ABM_AXI_RRESP(r_resp),
    .ABM_AXI_RLAST(r_last), .ABM_AXI_RREADY(r_ready),
    .PCI_AXI_AWADDR(aw_addr), .PCI_AXI_AWVALID(aw_valid), .PCI_AXI_AWLEN(aw_len),
    .PCI_AXI_AWSIZE(aw_size), .PCI_AXI_AWID(aw_id), .PCI_AXI_AWBURST(aw_burst),
    .PCI_AXI_AWLOCK(aw_lock), .PCI_AXI_AWCACHE(aw_cache), .PCI_AXI_AWQOS(aw_qos),
    .PCI_AXI_AWPROT(aw_prot), .PCI_AXI_AWREADY(aw_ready),
    .PCI_AXI_WDATA(w_data), .PCI_AXI_WSTRB(w_strb), .PCI_AXI_WVALID(w_valid),
    .PCI_AXI_WLAST(w_last), .PCI_AXI_WREADY(w_ready),
    .PCI_AXI_BRESP(b_resp), .PCI_AXI_BVALID(b_valid), .PCI_AXI_BREADY(b_ready)
  );

  int          n_assert = 0;
  int          n_fail   = 0;
  logic [63:0] sb [$];
  int          r_pending [$];
  int          r_beat, w_beat, b_pending, ar_wait;
  int          ar_count, aw_count, w_total, b_count, rx_total;
  int          ar_start, aw_start, w_start, b_start;
  int          ar_delay, aw_stall, w_stall, rerr_burst, rerr_beat, berr_burst;
  logic [63:0] dst_base;
  logic [31:0] epoch;

  function automatic logic [63:0] src_word(input logic [63:0] addr, input logic [31:0] ep);
    return {addr[31:0] ^ ep, ~addr[31:0]};
  endfunction

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("[TB] FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic clear_model();
    sb.delete();
    r_pending.delete();
    r_beat    = 0;
    w_beat    = 0;
    b_pending = 0;
    ar_wait   = 0;
    rx_total  = w_total;
    ar_ready  = 1'b0;
    r_valid   = 1'b0;
    r_data    = '0;
    r_resp    = 2'b00;
    r_last    = 1'b0;
    aw_ready  = 1'b0;
    w_ready   = 1'b0;
    b_valid   = 1'b0;
    b_resp    = 2'b00;
  endtask

  // Slave responders: choose inputs for the coming rising edge, then account
  // for every handshake that edge will complete.
  task automatic respond();
    logic [63:0] exp_word;
    bit          r_hs;
    int          k;
    if (reset) begin
      clear_model();
      return;
    end
    r_hs = 1'b0;
    if (b_pending > 0) begin
      b_valid = 1'b1;
      b_resp  = ((b_count - b_start) == berr_burst) ? 2'b10 : 2'b00;
      if (b_ready) begin
        b_pending--;
        b_count++;
      end
    end else begin
      b_valid = 1'b0;
      b_resp  = 2'b00;
    end
    if (r_pending.size() > 0) begin
      k       = r_pending[0];
      r_valid = 1'b1;
      r_data  = src_word(ABM_BASE + 64'(k * BURST_BYTES + r_beat * (DW / 8)), epoch);
      r_resp  = (k == rerr_burst && r_beat == rerr_beat) ? 2'b10 : 2'b00;
      r_last  = (r_beat == BEATS - 1);
      if (r_ready) begin
        sb.push_back(r_data);
        rx_total++;
        r_hs = 1'b1;
        r_beat++;
        if (r_beat == BEATS) begin
          r_beat = 0;
          void'(r_pending.pop_front());
        end
      end
    end else begin
      r_valid = 1'b0;
      r_last  = 1'b0;
    end
    ar_ready = ar_valid && (ar_wait >= ar_delay);
    if (ar_valid && ar_ready) begin
      check("ar_addr", ar_addr, ABM_BASE + 64'((ar_count - ar_start) * BURST_BYTES));
      check("ar_attr", 64'({ar_len, ar_size, ar_burst, ar_cache, ar_id, ar_lock, ar_qos, ar_prot}),
            64'(ATTR_EXP));
      r_pending.push_back(ar_count - ar_start);
      ar_count++;
      ar_wait = 0;
    end else if (ar_valid) begin
      ar_wait++;
    end
    w_ready = ($urandom_range(99) >= w_stall);
    if (w_valid && w_ready) begin
      if (sb.size() == 0) begin
        check("w_underflow", 64'(1), 64'(0));
      end else begin
        exp_word = sb.pop_front();
        check("w_data", w_data, exp_word);
      end
      check("w_last", 64'(w_last), 64'(w_beat == BEATS - 1));
      check("w_strb", 64'(w_strb), 64'hFF);
      w_total++;
      w_beat++;
      if (w_beat == BEATS) begin
        w_beat = 0;
        b_pending++;
      end
    end
    aw_ready = ($urandom_range(99) >= aw_stall);
    if (aw_valid && aw_ready) begin
      check("aw_addr", aw_addr, dst_base + 64'((aw_count - aw_start) * BURST_BYTES));
      check("aw_attr", 64'({aw_len, aw_size, aw_burst, aw_cache, aw_id, aw_lock, aw_qos, aw_prot}),
            64'(ATTR_EXP));
      aw_count++;
    end
    if (r_hs) check("read_ahead", 64'((rx_total - w_total) <= 2 * BEATS), 64'(1));
  endtask

  task automatic tick();
    @(negedge clk);
    respond();
  endtask

  task automatic apply_stimulus(input logic [63:0] addr, input logic unl);
    pci_dst_addr   = addr;
    unload         = unl;
    unload_wstrobe = 1'b1;
    tick();
    unload         = 1'b0;
    unload_wstrobe = 1'b0;
  endtask

  task automatic start_transfer(input logic [63:0] addr);
    dst_base = addr;
    epoch    = epoch + 32'h0101_0001;
    ar_start = ar_count;
    aw_start = aw_count;
    w_start  = w_total;
    b_start  = b_count;
    apply_stimulus(addr, 1'b1);
  endtask

  task automatic wait_idle(input int budget, input string tag);
    int n = 0;
    while (idle !== 1'b1 && n < budget) begin
      tick();
      n++;
    end
    check(tag, 64'(idle), 64'(1));
  endtask

  task automatic check_output(input logic exp_error);
    check("ar_bursts", 64'(ar_count - ar_start), 64'(NBURST));
    check("aw_bursts", 64'(aw_count - aw_start), 64'(NBURST));
    check("w_beats",   64'(w_total - w_start),   64'(NBURST * BEATS));
    check("b_resps",   64'(b_count - b_start),   64'(NBURST));
    check("sb_empty",  64'(sb.size()),           64'(0));
    check("error",     64'(error),               64'(exp_error));
  endtask

  task automatic check_quiet();
    check("quiet", 64'({ar_valid, r_ready, aw_valid, w_valid, b_ready}), 64'(0));
    check("idle_q", 64'({idle, slave_select}), 64'(2'b10));
  endtask

  initial begin
    int n;
    reset = 1'b1; pci_dst_addr = '0; unload = 1'b0; unload_wstrobe = 1'b0;
    ar_delay = 0; aw_stall = 0; w_stall = 0;
    rerr_burst = -1; rerr_beat = -1; berr_burst = -1;
    ar_count = 0; aw_count = 0; w_total = 0; b_count = 0;
    ar_start = 0; aw_start = 0; w_start = 0; b_start = 0;
    dst_base = '0; epoch = 32'h1234_0000;
    clear_model();

    repeat (3) tick();
    check_quiet();
    check("error_rst", 64'(error), 64'(0));
    reset = 1'b0;
    tick();

    $display("[TB] plain transfer");
    start_transfer(64'h1_0000_0000);
    check("idle_fall", 64'({idle, slave_select}), 64'(2'b01));
    wait_idle(3000, "t2_done");
    check_output(1'b0);

    $display("[TB] rejected requests");
    ar_start = ar_count;
    apply_stimulus(64'h0, 1'b1);
    apply_stimulus(64'h1000_0820, 1'b1);
    apply_stimulus(64'h1000_0800, 1'b0);
    repeat (4) tick();
    check("no_start", 64'({idle, slave_select}), 64'(2'b10));
    check("no_ar", 64'(ar_count - ar_start), 64'(0));

    $display("[TB] backpressure and address wrap");
    ar_delay = 5; aw_stall = 70; w_stall = 70;
    start_transfer(64'hFFFF_FFFF_FFFF_FE00);
    repeat (40) tick();
    apply_stimulus(64'h2000, 1'b1);
    wait_idle(8000, "t4_done");
    check_output(1'b0);

    $display("[TB] error responses");
    ar_delay = 0; aw_stall = 20; w_stall = 20;
    berr_burst = 5;
    start_transfer(64'h2_0000_0000);
    n = 0;
    while ((b_count - b_start) < 7 && n < 3000) begin
      tick();
      n++;
    end
    check("berr_seen", 64'(error), 64'(1));
    berr_burst = -1; rerr_burst = 9; rerr_beat = 3;
    wait_idle(3000, "t5a_done");
    check_output(1'b1);
    start_transfer(64'h2_0001_0000);
    check("err_clear", 64'(error), 64'(0));
    rerr_burst = 0; rerr_beat = 7;
    wait_idle(3000, "t5b_done");
    check_output(1'b1);
    rerr_burst = -1; rerr_beat = -1;
    start_transfer(64'h2_0002_0000);
    check("err_clear2", 64'(error), 64'(0));
    wait_idle(3000, "t5c_done");
    check_output(1'b0);

    $display("[TB] reset mid transfer");
    aw_stall = 0; w_stall = 0;
    start_transfer(64'h3_0000_0000);
    n = 0;
    while ((w_total - w_start) < 100 && n < 3000) begin
      tick();
      n++;
    end
    check("reach_100", 64'((w_total - w_start) >= 100), 64'(1));
    reset = 1'b1;
    clear_model();
    tick();
    check_quiet();
    reset = 1'b0;
    tick();
    start_transfer(64'h3_0000_0000);
    wait_idle(3000, "t6_done");
    check_output(1'b0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
